// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the March C- style RAM BIST.
package ram_bist_pkg;

    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, DONE} state_e;

    // Second phase is a write in M1/M2 and a pure check in M3.
    typedef enum logic {RD, WR_CHK} phase_e;

    localparam logic [7:0] BG_DEF = 8'h55;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/ram_march_bist_if.sv
// RAM port bundle between the BIST initiator (master) and the RAM (slave).
interface ram_march_bist_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (output mem_we, mem_addr, mem_din, input mem_dout);
    modport slave  (input mem_we, mem_addr, mem_din, output mem_dout);
endinterface

// File: rtl/bist_addr_gen.sv
// Up/down address counter for the March elements; load snaps to the element start.
module bist_addr_gen
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_i,
    input  logic              ld_up_i,
    input  logic              step_i,
    input  logic              up_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (ld_i)
            addr_d = (ld_up_i == DIR_UP) ? '0 : '1;
        else if (step_i)
            addr_d = (up_i == DIR_UP) ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_q <= '0;
        else        addr_q <= addr_d;
    end

    assign addr_o = addr_q;
    // Last address of the element in the current sweep direction.
    assign last_o = (up_i == DIR_UP) ? (addr_q == '1) : (addr_q == '0);
endmodule

// File: rtl/ram_march_bist.sv
// March BIST initiator: sequences M0..M3 over the RAM, compares read data, reports results.
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int              ADDR_W = 4,
    parameter int              DATA_W = 8,
    parameter logic [DATA_W-1:0] BG   = DATA_W'(BG_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [7:0]        err_cnt,
    ram_march_bist_if.master  mem
);
    state_e            state_q;
    phase_e            phase_q;
    logic              busy_q, done_q, pass_q, we_q;
    logic [DATA_W-1:0] din_q, fail_data_q;
    logic [ADDR_W-1:0] fail_addr_q, addr;
    logic [7:0]        err_q, err_d;
    logic              ld, ld_up, step, up, last, cmp_en, mism;
    logic [DATA_W-1:0] exp_d;

    bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
        .clk(clk), .rst_n(rst_n), .ld_i(ld), .ld_up_i(ld_up),
        .step_i(step), .up_i(up), .addr_o(addr), .last_o(last)
    );

    // Counter control and compare enable for the cycle now on the RAM ports.
    always_comb begin
        ld = 1'b0; ld_up = DIR_UP; step = 1'b0; up = DIR_UP;
        cmp_en = 1'b0; exp_d = BG;
        unique case (state_q)
            IDLE: begin ld = start; end
            M0: begin
                if (last) ld = 1'b1; else step = 1'b1;
            end
            M1, M2, M3: begin
                up    = (state_q == M1) ? DIR_UP : DIR_DN;
                exp_d = (state_q == M2) ? ~BG : BG;
                if (phase_q == WR_CHK) begin
                    cmp_en = 1'b1;
                    if (last) begin
                        ld    = 1'b1;
                        ld_up = (state_q == M3) ? DIR_UP : DIR_DN;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign mism  = cmp_en && (mem.mem_dout != exp_d);
    assign err_d = (mism && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;   phase_q <= RD;
            busy_q  <= 1'b0;   done_q  <= 1'b0;  pass_q <= 1'b0;  we_q <= 1'b0;
            din_q   <= '0;     fail_addr_q <= '0; fail_data_q <= '0; err_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= M0;   busy_q <= 1'b1;
                        we_q    <= 1'b1; din_q  <= BG;
                        err_q   <= '0;   pass_q <= 1'b0;
                        fail_addr_q <= '0; fail_data_q <= '0;
                    end
                end
                M0: if (last) begin
                    state_q <= M1; phase_q <= RD; we_q <= 1'b0;
                end
                M1, M2: begin
                    if (phase_q == RD) begin
                        phase_q <= WR_CHK; we_q <= 1'b1;
                        din_q   <= (state_q == M1) ? ~BG : BG;
                    end else begin
                        phase_q <= RD; we_q <= 1'b0;
                        if (last) state_q <= (state_q == M1) ? M2 : M3;
                    end
                end
                M3: begin
                    if (phase_q == RD) begin
                        phase_q <= WR_CHK;
                    end else begin
                        phase_q <= RD;
                        if (last) begin
                            state_q <= DONE; busy_q <= 1'b0; done_q <= 1'b1;
                            pass_q  <= (err_d == 8'd0); din_q <= '0;
                        end
                    end
                end
                DONE: begin state_q <= IDLE; done_q <= 1'b0; end
                default: state_q <= IDLE;
            endcase
            // Only the first mismatch of a run is captured; later ones just count.
            if (mism) begin
                err_q <= err_d;
                if (err_q == 8'd0) begin
                    fail_addr_q <= addr;
                    fail_data_q <= mem.mem_dout;
                end
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign fail_addr    = fail_addr_q;
    assign fail_data    = fail_data_q;
    assign err_cnt      = err_q;
    assign mem.mem_we   = we_q;
    assign mem.mem_addr = addr;
    assign mem.mem_din  = din_q;
endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: faulty-RAM model, abstract March reference, per-cycle port checks.
module tb_ram_march_bist;
    localparam int AW = 4, DW = 8, N = 16;
    localparam logic [7:0] BG = 8'h55, NBG = 8'hAA;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr = 1'b0;
    logic busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [7:0]    err_cnt;

    ram_march_bist_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

    ram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .BG(BG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .pass(pass), .fail_addr(fail_addr), .fail_data(fail_data),
        .err_cnt(err_cnt), .mem(mem_if)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;

    // Fault modes: 0 none, 1 stuck bit on faddr, 2 faddr ignores writes after its first, 3 all reads 0.
    int   fmode = 0, faddr = 0, fbit = 0;
    logic fval = 1'b0;

    logic [7:0] ram [N];
    bit         wrote [N];
    logic [7:0] dout_q;

    function automatic logic [7:0] rd_cell(input int a, input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (fmode == 1 && a == faddr) r[fbit] = fval;
        if (fmode == 3) r = 8'h00;
        return r;
    endfunction

    always @(posedge clk) begin
        dout_q <= rd_cell(int'(mem_if.mem_addr), ram[mem_if.mem_addr]);
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                ram[i]   <= 8'($urandom);
                wrote[i] <= 1'b0;
            end
        end else if (mem_if.mem_we) begin
            if (!(fmode == 2 && int'(mem_if.mem_addr) == faddr && wrote[mem_if.mem_addr]))
                ram[mem_if.mem_addr] <= mem_if.mem_din;
            wrote[mem_if.mem_addr] <= 1'b1;
        end
    end
    assign mem_if.mem_dout = dout_q;

    // Abstract reference: run the March element by element on a private copy of the RAM.
    logic [7:0] mm [N];
    bit         mw [N];
    int         e_err, e_fa, e_fd;

    function automatic void mwr(input int a, input logic [7:0] d);
        if (!(fmode == 2 && a == faddr && mw[a])) mm[a] = d;
        mw[a] = 1'b1;
    endfunction

    function automatic void mchk(input int a, input logic [7:0] e);
        logic [7:0] v;
        v = rd_cell(a, mm[a]);
        if (v != e) begin
            if (e_err == 0) begin e_fa = a; e_fd = int'(v); end
            if (e_err < 255) e_err++;
        end
    endfunction

    task automatic model_run();
        e_err = 0; e_fa = 0; e_fd = 0;
        for (int a = 0; a < N; a++) begin mm[a] = 8'h00; mw[a] = 1'b0; end
        for (int a = 0; a < N; a++) mwr(a, BG);
        for (int a = 0; a < N; a++) begin mchk(a, BG);  mwr(a, NBG); end
        for (int a = N-1; a >= 0; a--) begin mchk(a, NBG); mwr(a, BG); end
        for (int a = N-1; a >= 0; a--) mchk(a, BG);
    endtask

    // Expected RAM port activity in cycle k of a run.
    task automatic sched(input int k, output bit we, output int addr, output logic [7:0] din);
        int j;
        din = BG;
        if (k < N)          begin we = 1'b1; addr = k; end
        else if (k < 3*N)   begin j = k - N;   we = j[0]; addr = j / 2;         din = NBG; end
        else if (k < 5*N)   begin j = k - 3*N; we = j[0]; addr = N - 1 - j / 2; end
        else                begin j = k - 5*N; we = 1'b0; addr = N - 1 - j / 2; end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after done.
    task automatic run_test(input string tag, input bit hold, input int pulse_k, input int rst_k);
        bit we; int ad; logic [7:0] dn;
        model_run();
        clr = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        if (!hold) start = 1'b0;
        for (int k = 0; k < 7*N; k++) begin
            @(negedge clk);
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                chk({tag, " rst busy"}, busy, 0);       chk({tag, " rst done"}, done, 0);
                chk({tag, " rst pass"}, pass, 0);       chk({tag, " rst we"}, mem_if.mem_we, 0);
                chk({tag, " rst addr"}, mem_if.mem_addr, 0); chk({tag, " rst din"}, mem_if.mem_din, 0);
                chk({tag, " rst err"}, err_cnt, 0);     chk({tag, " rst faddr"}, fail_addr, 0);
                chk({tag, " rst fdata"}, fail_data, 0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                @(negedge clk);
                chk({tag, " idle after rst"}, busy, 0);
                return;
            end
            sched(k, we, ad, dn);
            chk($sformatf("%s k%0d busy", tag, k), busy, 1);
            chk($sformatf("%s k%0d done", tag, k), done, 0);
            chk($sformatf("%s k%0d we", tag, k), mem_if.mem_we, we);
            chk($sformatf("%s k%0d addr", tag, k), mem_if.mem_addr, ad);
            if (we) chk($sformatf("%s k%0d din", tag, k), mem_if.mem_din, dn);
            if (k == 0) begin
                chk({tag, " cleared err"}, err_cnt, 0);   chk({tag, " cleared pass"}, pass, 0);
                chk({tag, " cleared faddr"}, fail_addr, 0); chk({tag, " cleared fdata"}, fail_data, 0);
            end
            if (k == pulse_k)     start = 1'b1;
            if (k == pulse_k + 1) start = 1'b0;
        end
        @(negedge clk);
        chk({tag, " done pulse"}, done, 1);   chk({tag, " done busy"}, busy, 0);
        chk({tag, " done we"}, mem_if.mem_we, 0);
        chk({tag, " pass"}, pass, e_err == 0);
        chk({tag, " err_cnt"}, err_cnt, e_err);
        chk({tag, " fail_addr"}, fail_addr, e_fa);
        chk({tag, " fail_data"}, fail_data, e_fd);
        @(negedge clk);
        chk({tag, " done drop"}, done, 0);    chk({tag, " idle busy"}, busy, 0);
        chk({tag, " hold err"}, err_cnt, e_err);
        chk({tag, " hold pass"}, pass, e_err == 0);
    endtask

    initial begin
        @(negedge clk);
        chk("reset busy", busy, 0);  chk("reset we", mem_if.mem_we, 0);
        chk("reset err", err_cnt, 0); chk("reset pass", pass, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        fmode = 0;
        run_test("good", 0, -10, -1);
        chk("good pass lit", pass, 1); chk("good err lit", err_cnt, 0); chk("good faddr lit", fail_addr, 0);

        fmode = 1; faddr = 5; fbit = 0; fval = 1'b0;
        run_test("sa0", 0, -10, -1);
        chk("sa0 faddr lit", fail_addr, 5); chk("sa0 fdata lit", fail_data, 8'h54);
        chk("sa0 err lit", err_cnt, 2);     chk("sa0 pass lit", pass, 0);

        fmode = 2; faddr = 12;
        run_test("wlock", 0, -10, -1);
        chk("wlock faddr lit", fail_addr, 12); chk("wlock fdata lit", fail_data, 8'h55);
        chk("wlock err lit", err_cnt, 1);

        fmode = 1; faddr = 5; fbit = 0; fval = 1'b0;
        run_test("sa0 pulse", 0, 40, -1);
        chk("pulse err lit", err_cnt, 2); chk("pulse faddr lit", fail_addr, 5);

        fmode = 0;
        run_test("midrst", 0, -10, 60);
        run_test("after rst", 0, -10, -1);
        chk("after rst pass lit", pass, 1);

        fmode = 3;
        run_test("zero1", 1, -10, -1);
        run_test("zero2", 0, -10, -1);
        chk("zero faddr lit", fail_addr, 0); chk("zero fdata lit", fail_data, 8'h00);

        for (int r = 0; r < 6; r++) begin
            fmode = (r % 2 == 0) ? 1 : 2;
            faddr = $urandom_range(N - 1);
            fbit  = $urandom_range(DW - 1);
            fval  = 1'($urandom);
            repeat ($urandom_range(3)) @(negedge clk);
            run_test($sformatf("rnd%0d m%0d a%0d b%0d v%0d", r, fmode, faddr, fbit, fval),
                     0, (r == 3) ? int'($urandom_range(100)) : -10, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
